sha3_input_padder: RTL
======================

# sha3_input_padder

Receiving end of the 64-bit message-word stream driven into the hash core. Accepts words on `in`/`in_ready`, applies Keccak multi-rate padding using `is_last`/`byte_num`, and assembles 1088-bit rate blocks for the permutation stage. Presents each block on `out`/`out_ready`, holds it until the permutation acknowledges it on `f_ack`, and throttles the sender with `buffer_full`.

## Interface
- `RATE_WORDS`, 17: 64-bit words per block; 1088-bit rate.
- `PAD_FIRST`, 8'h01: domain/pad byte written immediately after the last message byte.
- `PAD_LAST`, 8'h80: ORed into the final byte of every padded block.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in` in 64: message word; first message byte in `in[63:56]`.
- `in_ready` in 1: `in` is valid this cycle.
- `is_last` in 1: this word is the final word of the message.
- `byte_num` in 3: number of valid bytes (0..7) in the final word; ignored unless `is_last`=1.
- `buffer_full` out 1: sender must not present words; registered.
- `out` out 1088: assembled block; slot 0 in `out[1087:1024]`, slot 16 in `out[63:0]`.
- `out_ready` out 1: `out` holds a complete block; registered.
- `f_ack` in 1: one-cycle pulse from the permutation: block consumed.

## Operation
- State: `ACCEPT`, `FULL`. Registers: `block[RATE_WORDS]`, `count` (0..17, 5 bits), `last_seen`.
- Accept condition: `in_ready && state==ACCEPT`. Words presented while `buffer_full`=1 are ignored, not queued.
- Normal word (`is_last`=0): `block[count] <= in`; `count++`. If `count` becomes 17, go to `FULL`.
- Last word: `block[count] <= pad_word(in, byte_num)`:
  - bytes 0..n-1 are taken from `in`, with n = `byte_num`;
  - byte n = `PAD_FIRST`;
  - bytes above n = 0.
- Also on the last word: the LSB byte of `block[16]` is ORed with `PAD_LAST`. When `count`==16, that OR combines with the pad word, e.g. n=7 gives LSB byte 0x81. Then set `last_seen`=1 and go to `FULL`.
- Slots above `count` remain zero because the block is cleared on every acknowledge.
- `FULL`: `out_ready`=1, `buffer_full`=1. On `f_ack`:
  - clear `block` and `count`;
  - clear `last_seen`;
  - return to `ACCEPT`.
- Message continues after a full block: `is_last` always arrives with a word, so padding always lands in a fresh block. A message of exactly 17k words plus an empty last word yields k+1 blocks.
- `f_ack` outside `FULL` is ignored.
- Simultaneous `in_ready` and `f_ack` in `FULL`: the ack is taken and the word is ignored. The sender sees `buffer_full`=1 that cycle.
- Reset mid-block: everything clears asynchronously. The partial message is discarded.

## Timing
- Reset values:
  - `buffer_full`=0, `out_ready`=0, `out`=0;
  - `count`=0, `state`=`ACCEPT`.
- Latency: a word accepted at edge t is visible in `out` after t.
- Block ready: on the 17th or last word accepted at edge t, `out_ready` and `buffer_full` are 1 from t until the edge that samples `f_ack`. Both return to 0 on that edge, and `out` is zero afterwards.
- Throughput: 1 word/cycle while in `ACCEPT`.
- Minimum block turnaround: 1 cycle in `FULL` when `f_ack` is immediate.
- `buffer_full` depends only on registered state, with no combinational path from inputs. The sender may sample it before driving.

## Structure
- The shared package `defs` holds:
  - `packet_input` (logic[63:0]);
  - a new `rate_block_t` (logic[1087:0]);
  - constants `RATE_WORDS`, `PAD_FIRST`, `PAD_LAST`.
- One combinational sub-module, `pad_word_gen`: (word, byte_num) to padded word, containing the byte mask and `PAD_FIRST` insertion. The `PAD_LAST` OR stays in the top-level, since it depends on the slot.

## Test plan
- **Empty message:** `is_last`=1, `byte_num`=0, `in`=x → `out_ready` next cycle; slot0=0x0100000000000000; slot16=0x0000000000000080; other slots 0.
- **"abc":** `in`=0x6162632020202020, `byte_num`=3, `is_last`=1 → slot0=0x6162630100000000; slot16 LSB byte=0x80.
- **8 bytes then empty last:** 0x3132333435363738 (`is_last`=0), then 0 with `is_last`=1, `byte_num`=0 → slot0=data; slot1=0x0100000000000000.
- **17 full words then last with `byte_num`=2:**
  - after the 17th word, `buffer_full`=1 and `out_ready`=1;
  - words held during the stall are not absorbed;
  - `f_ack` → second block with slot0 = 2 data bytes, then 0x01, then zeros.
- **16 words then last with `byte_num`=7:** slot16 = 7 data bytes followed by LSB byte 0x81.
- **Reset mid-message:** 5 words, then `reset` pulse → `count`=0, `out`=0, flags low. The next empty message produces the same block as the empty-message scenario.

Source files
------------

// File: rtl/defs.sv
// Shared types and constants for the SHA-3 message input path.
package defs;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned RATE_WORDS = 17;
  localparam int unsigned RATE_W     = WORD_W * RATE_WORDS;

  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef logic [WORD_W-1:0] packet_input;
  typedef logic [RATE_W-1:0] rate_block_t;

endpackage

// File: rtl/pad_word_gen.sv
// Keeps the first byte_num bytes of a word (MSB first), inserts the pad byte after them, zeroes the rest.
module pad_word_gen
  import defs::*;
(
  input  packet_input word,
  input  logic [2:0]  byte_num,
  output packet_input padded_c
);

  always_comb begin
    padded_c = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) < byte_num) begin
        padded_c[63-8*i -: 8] = word[63-8*i -: 8];
      end else if (3'(i) == byte_num) begin
        padded_c[63-8*i -: 8] = PAD_FIRST;
      end
    end
  end

endmodule

// File: rtl/sha3_input_padder.sv
// Collects 64-bit message words into padded 1088-bit rate blocks and holds each
// block until the permutation acknowledges it.
module sha3_input_padder
  import defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  packet_input in,
  input  logic        in_ready,
  input  logic        is_last,
  input  logic [2:0]  byte_num,
  output logic        buffer_full,
  output rate_block_t out,
  output logic        out_ready,
  input  logic        f_ack
);

  localparam logic [0:0] ACCEPT = 1'b0;
  localparam logic [0:0] FULL   = 1'b1;

  logic [0:0]  state, state_n;
  logic [4:0]  count, count_n;
  logic        last_seen, last_seen_n;
  rate_block_t block, block_n;
  packet_input padded;
  int unsigned slot_lsb;

  pad_word_gen u_pad (
    .word     (in),
    .byte_num (byte_num),
    .padded_c (padded)
  );

  // Slot 0 sits at the top of the block, so the write position counts down.
  assign slot_lsb = (RATE_WORDS - 1 - 32'(count)) * WORD_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ACCEPT;
      count       <= '0;
      last_seen   <= 1'b0;
      block       <= '0;
      out_ready   <= 1'b0;
      buffer_full <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      last_seen   <= last_seen_n;
      block       <= block_n;
      out_ready   <= (state_n == FULL);
      buffer_full <= (state_n == FULL);
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    last_seen_n = last_seen;
    block_n     = block;
    case (state)
      ACCEPT: begin
        if (in_ready) begin
          count_n = count + 5'd1;
          if (is_last) begin
            block_n[slot_lsb +: WORD_W] = padded;
            // Applied after the slot write so a pad word in slot 16 keeps both markers.
            block_n[7:0] = block_n[7:0] | PAD_LAST;
            last_seen_n  = 1'b1;
            state_n      = FULL;
          end else begin
            block_n[slot_lsb +: WORD_W] = in;
            if (count == 5'(RATE_WORDS - 1)) state_n = FULL;
          end
        end
      end
      FULL: begin
        if (f_ack) begin
          block_n     = '0;
          count_n     = '0;
          last_seen_n = 1'b0;
          state_n     = ACCEPT;
        end
      end
      default: state_n = ACCEPT;
    endcase
  end

  assign out = block;

  a_last_only_when_full: assert property (@(posedge clk) disable iff (reset)
    last_seen |-> (state == FULL));

endmodule
